spi_flash_loader: RTL and testbench

- Bus-master sequencer that copies a block of SPI flash contents into system RAM at boot or on CPU request.
- Sits directly upstream of the SPI flash controller and drives its 16-register port: command/address/dummy bytes go in, received bytes come out.
- Received bytes are written to RAM through a single-cycle write port.
- One byte in flight at a time; completion of each byte is detected from the controller's rx toggle bit.

---
 rtl/spi_flash_loader_if.sv | 27 ++
 rtl/spi_flash_loader.sv | 130 +++++++++++++
 tb/tb_spi_flash_loader.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_loader_if.sv
// Job request, SPI controller register port and RAM write port of the flash loader.
// The master modport is the loader and the slave modport is the surrounding system.
interface spi_flash_loader_if;
  logic        start;
  logic [23:0] flash_addr;
  logic [15:0] length;
  logic [15:0] mem_base;
  logic        busy;
  logic        done;
  logic [3:0]  spi_addr;
  logic        spi_we;
  logic [7:0]  spi_dbw;
  logic [7:0]  spi_dbr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dbw;
  logic        mem_we;

  modport master (
    input  start, flash_addr, length, mem_base, spi_dbr,
    output busy, done, spi_addr, spi_we, spi_dbw, mem_addr, mem_dbw, mem_we
  );

  modport slave (
    output start, flash_addr, length, mem_base, spi_dbr,
    input  busy, done, spi_addr, spi_we, spi_dbw, mem_addr, mem_dbw, mem_we
  );
endinterface

// File: rtl/spi_flash_loader.sv
// Copies a block of SPI flash into RAM, one byte in flight, through the controller's register port.
// Optional: define SPI_LOADER_FAST_READ_EN for the 0x0B fast-read command with one dummy byte.
module spi_flash_loader #(
  parameter logic [7:0] READ_CMD = 8'h03,
  parameter logic [7:0] DUMMY_TX = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_flash_loader_if.master   bus
);

`ifdef SPI_LOADER_FAST_READ_EN
  localparam logic [7:0]  OPCODE  = 8'h0B;
  localparam logic [16:0] CMD_LEN = 17'd5;
`else
  localparam logic [7:0]  OPCODE  = READ_CMD;
  localparam logic [16:0] CMD_LEN = 17'd4;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_REL, S_SNAP, S_SEND, S_POLL, S_RDAT, S_STORE, S_FIN
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_done;
  logic        r_tog0;
  logic [16:0] r_idx;     // byte index within the CS frame, command bytes included
  logic [23:0] r_flash;
  logic [15:0] r_len;
  logic [15:0] r_base;

  logic        w_data;
  logic        w_last;
  logic [15:0] w_k;
  logic [7:0]  w_tx_byte;

  assign w_data = (r_idx >= CMD_LEN);
  assign w_last = ((r_idx + 17'd1) == (CMD_LEN + {1'b0, r_len}));
  assign w_k    = r_idx[15:0] - CMD_LEN[15:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done  <= 1'b0;
      r_tog0  <= 1'b0;
      r_idx   <= 17'd0;
      r_flash <= 24'd0;
      r_len   <= 16'd0;
      r_base  <= 16'd0;
    end else begin
      r_done <= (r_state == S_FIN) ||
                ((r_state == S_IDLE) && bus.start && (bus.length == 16'd0));
      if ((r_state == S_IDLE) && bus.start) begin
        r_flash <= bus.flash_addr;
        r_len   <= bus.length;
        r_base  <= bus.mem_base;
        r_idx   <= 17'd0;
      end
      if (r_state == S_SEND) begin
        r_tog0 <= bus.spi_dbr[6];
      end
      if (r_state == S_STORE) begin
        r_idx <= r_idx + 17'd1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start && (bus.length != 16'd0)) w_state_next = S_REL;
      S_REL:   w_state_next = S_SNAP;
      S_SNAP:  w_state_next = S_SEND;
      S_SEND:  w_state_next = S_POLL;
      // The first POLL cycle still shows the SNAP status, so it cannot exit early.
      S_POLL:  if (bus.spi_dbr[6] != r_tog0) w_state_next = S_RDAT;
      S_RDAT:  w_state_next = S_STORE;
      S_STORE: w_state_next = w_last ? S_FIN : S_SNAP;
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    case (r_idx)
      17'd0:   w_tx_byte = OPCODE;
      17'd1:   w_tx_byte = r_flash[23:16];
      17'd2:   w_tx_byte = r_flash[15:8];
      17'd3:   w_tx_byte = r_flash[7:0];
      default: w_tx_byte = DUMMY_TX;
    endcase
  end

  always_comb begin
    bus.busy     = (r_state != S_IDLE);
    bus.done     = r_done;
    bus.spi_we   = 1'b0;
    bus.spi_addr = 4'd0;
    bus.spi_dbw  = 8'd0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 16'd0;
    bus.mem_dbw  = 8'd0;
    case (r_state)
      S_REL, S_FIN: bus.spi_we = 1'b1;
      S_SEND: begin
        bus.spi_we   = 1'b1;
        bus.spi_addr = 4'd1;
        bus.spi_dbw  = w_tx_byte;
      end
      S_RDAT: bus.spi_addr = 4'd1;
      S_STORE: begin
        if (w_data) begin
          bus.mem_we   = 1'b1;
          bus.mem_addr = r_base + w_k;
          bus.mem_dbw  = bus.spi_dbr;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_flash_loader.sv
// Bench for spi_flash_loader: SPI controller + flash model, job-level scoreboard and directed jobs.
module tb_spi_flash_loader;

`ifdef SPI_LOADER_FAST_READ_EN
  localparam int         TB_CMD_LEN = 5;
  localparam logic [7:0] TB_OPCODE  = 8'h0B;
`else
  localparam int         TB_CMD_LEN = 4;
  localparam logic [7:0] TB_OPCODE  = 8'h03;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_flash_loader_if bus();

  spi_flash_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Flash contents: byte at address a is 0xA0 + (a - 0x012345), truncated to 8 bits.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    logic [23:0] d;
    d = a - 24'h012345;
    return 8'hA0 + d[7:0];
  endfunction

  // Controller + flash model. Read data register only reloads when not writing.
  int         c_cnt = 0;
  int         c_n   = 0;
  logic       c_tog = 1'b0;
  logic       c_cs  = 1'b1;
  logic [7:0] c_rx  = 8'h00;
  logic [7:0] c_fr [0:4];

  function automatic logic [7:0] rx_value(input int n);
    if (n < TB_CMD_LEN) return 8'hC3;
    return flash_byte({c_fr[1], c_fr[2], c_fr[3]} + 24'(n - TB_CMD_LEN));
  endfunction

  always @(posedge clk) begin
    if (!bus.spi_we)
      bus.spi_dbr <= (bus.spi_addr == 4'd0) ? {(c_cnt != 0), c_tog, 5'b0, c_cs} : c_rx;
    if (bus.spi_we && bus.spi_addr == 4'd0) begin
      c_cs <= 1'b1;
      c_n  <= 0;
    end else if (bus.spi_we && bus.spi_addr == 4'd1) begin
      c_cs <= 1'b0;
      if (c_n < 5) c_fr[c_n] <= bus.spi_dbw;
      c_cnt <= 17;
    end else if (c_cnt == 1) begin
      c_cnt <= 0;
      c_tog <= ~c_tog;
      c_rx  <= rx_value(c_n);
      c_n   <= c_n + 1;
    end else if (c_cnt > 1) begin
      c_cnt <= c_cnt - 1;
    end
  end

  // Job-level expectations and observation logs.
  logic [7:0]  exp_mosi  [$];
  logic [15:0] exp_maddr [$];
  logic [7:0]  exp_mdata [$];
  logic [7:0]  obs_mosi  [$];
  logic [15:0] obs_maddr [$];
  logic [7:0]  obs_mdata [$];
  int spi_we_cnt = 0;
  int mem_cnt    = 0;
  int done_cnt   = 0;
  bit first_after_rst = 1'b0;

  task automatic expect_job(input logic [23:0] fa, input logic [15:0] len, input logic [15:0] base);
    exp_mosi.push_back(TB_OPCODE);
    exp_mosi.push_back(fa[23:16]);
    exp_mosi.push_back(fa[15:8]);
    exp_mosi.push_back(fa[7:0]);
    if (TB_CMD_LEN == 5) exp_mosi.push_back(8'h00);
    for (int k = 0; k < int'(len); k++) begin
      exp_mosi.push_back(8'h00);
      exp_maddr.push_back(base + 16'(k));
      exp_mdata.push_back(flash_byte(fa + 24'(k)));
    end
  endtask

  // Compare process: every cycle out of reset.
  initial begin
    bit prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_busy = 1'b0;
        continue;
      end
      if (bus.spi_we) begin
        spi_we_cnt++;
        if (first_after_rst) begin
          chk("first_spi_is_reg0", 32'(bus.spi_addr), 32'd0);
          first_after_rst = 1'b0;
        end
        if (bus.spi_addr == 4'd1) begin
          obs_mosi.push_back(bus.spi_dbw);
          if (exp_mosi.size() == 0) chk("mosi_extra", 32'd1, 32'd0);
          else chk("mosi_byte", 32'(bus.spi_dbw), 32'(exp_mosi.pop_front()));
        end
      end
      if (bus.mem_we) begin
        mem_cnt++;
        obs_maddr.push_back(bus.mem_addr);
        obs_mdata.push_back(bus.mem_dbw);
        if (exp_maddr.size() == 0) chk("mem_extra", 32'd1, 32'd0);
        else begin
          chk("mem_addr", 32'(bus.mem_addr), 32'(exp_maddr.pop_front()));
          chk("mem_data", 32'(bus.mem_dbw), 32'(exp_mdata.pop_front()));
        end
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_busy_low", 32'(bus.busy), 32'd0);
      end
      if (prev_busy && !bus.busy) chk("busy_fall_done", 32'(bus.done), 32'd1);
      prev_busy = bus.busy;
    end
  end

  task automatic clear_logs();
    obs_mosi.delete();
    obs_maddr.delete();
    obs_mdata.delete();
    spi_we_cnt = 0;
    mem_cnt    = 0;
    done_cnt   = 0;
  endtask

  task automatic run_job(input logic [23:0] fa, input logic [15:0] len, input logic [15:0] base,
                         input bit inject);
    int lim;
    bit seen;
    expect_job(fa, len, base);
    clear_logs();
    @(negedge clk);
    bus.flash_addr = fa;
    bus.length     = len;
    bus.mem_base   = base;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lim  = (int'(len) + 6) * 40;
    seen = 1'b0;
    for (int c = 0; c < lim; c++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (inject && c == 40) begin
        bus.flash_addr = 24'hABCDEF;
        bus.length     = 16'd9;
        bus.mem_base   = 16'h7777;
        bus.start      = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("job_done_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    chk("mosi_left", 32'(exp_mosi.size()), 32'd0);
    chk("mem_left", 32'(exp_maddr.size()), 32'd0);
    chk("done_count", 32'(done_cnt), 32'd1);
    $display("job flash=%06h len=%0d base=%04h: spi_we=%0d mem_we=%0d done=%0d",
             fa, len, base, spi_we_cnt, mem_cnt, done_cnt);
  endtask

  logic [7:0]  basic_mosi [8] = '{8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [15:0] wrap_addr  [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
`ifdef SPI_LOADER_FAST_READ_EN
  logic [7:0]  fast_mosi  [7] = '{8'h0B, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
`else
  logic [7:0]  fast_mosi  [6] = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
`endif

  initial begin
    bit seen;
    bus.start      = 1'b0;
    bus.flash_addr = 24'd0;
    bus.length     = 16'd0;
    bus.mem_base   = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_spi_we", 32'(bus.spi_we), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic read
    run_job(24'h012345, 16'd4, 16'h0200, 1'b0);
    if (TB_CMD_LEN == 4) begin
      chk("basic_mosi_len", 32'(obs_mosi.size()), 32'd8);
      for (int i = 0; i < 8; i++) chk("basic_mosi_lit", 32'(obs_mosi[i]), 32'(basic_mosi[i]));
      chk("basic_spi_we_cnt", 32'(spi_we_cnt), 32'd10);
    end
    chk("basic_mem_cnt", 32'(mem_cnt), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("basic_maddr_lit", 32'(obs_maddr[i]), 32'h0200 + 32'(i));
      chk("basic_mdata_lit", 32'(obs_mdata[i]), 32'hA0 + 32'(i));
    end

    // Zero length
    clear_logs();
    @(negedge clk);
    bus.length = 16'd0;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("zl_done", 32'(bus.done), 32'd1);
    chk("zl_busy", 32'(bus.busy), 32'd0);
    repeat (4) @(negedge clk);
    chk("zl_spi_we", 32'(spi_we_cnt), 32'd0);
    chk("zl_mem_we", 32'(mem_cnt), 32'd0);
    chk("zl_done_cnt", 32'(done_cnt), 32'd1);
    $display("job zero-length: spi_we=%0d mem_we=%0d done=%0d", spi_we_cnt, mem_cnt, done_cnt);

    // Address wrap
    run_job(24'h012345, 16'd4, 16'hFFFE, 1'b0);
    for (int i = 0; i < 4; i++) chk("wrap_maddr_lit", 32'(obs_maddr[i]), 32'(wrap_addr[i]));

    // Start while busy
    run_job(24'h012345, 16'd4, 16'h0200, 1'b1);
    chk("busy_start_mem_cnt", 32'(mem_cnt), 32'd4);
    chk("busy_start_mdata3", 32'(obs_mdata[3]), 32'hA3);

    // Reset mid-job during POLL of byte 6
    exp_mosi.delete();
    exp_maddr.delete();
    exp_mdata.delete();
    expect_job(24'h012345, 16'd8, 16'h0400);
    clear_logs();
    @(negedge clk);
    bus.flash_addr = 24'h012345;
    bus.length     = 16'd8;
    bus.mem_base   = 16'h0400;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (obs_mosi.size() >= 6) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("mid_reach_byte6", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_spi", {22'd0, bus.spi_we, bus.spi_addr, bus.spi_dbw}, 32'd0);
    chk("mid_rst_mem", {7'd0, bus.mem_we, bus.mem_addr, bus.mem_dbw}, 32'd0);
    exp_mosi.delete();
    exp_maddr.delete();
    exp_mdata.delete();
    done_cnt = 0;
    repeat (3) @(negedge clk);
    first_after_rst = 1'b1;
    rst = 1'b1;
    repeat (25) @(negedge clk);
    chk("mid_no_done", 32'(done_cnt), 32'd0);
    $display("job aborted by reset: mem_we=%0d done=%0d", mem_cnt, done_cnt);
    run_job(24'h012345, 16'd8, 16'h0400, 1'b0);
    chk("mid_first_checked", 32'(first_after_rst), 32'd0);
    chk("mid_mdata7", 32'(obs_mdata[7]), 32'hA7);

    // Fast-read vector (opcode and dummy count follow the build option)
    run_job(24'h000010, 16'd2, 16'h0300, 1'b0);
    chk("fast_mosi_len", 32'(obs_mosi.size()), 32'($size(fast_mosi)));
    for (int i = 0; i < $size(fast_mosi); i++) chk("fast_mosi_lit", 32'(obs_mosi[i]), 32'(fast_mosi[i]));
    chk("fast_mem_cnt", 32'(mem_cnt), 32'd2);
    chk("fast_mdata0", 32'(obs_mdata[0]), 32'h6B);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
